// File: rtl/uart_tx_arbiter_if.sv
// Purpose : bundles the requester-side and uart-side signals of the uart tx arbiter.
// Latency : none (wiring only).
// Backpressure: req is a level held until done/err; tx_empty from the uart paces transfers.
// Ports (slave view = the arbiter):
//   in : arb_enable, req[NUM_REQ], req_data[8*NUM_REQ], tx_empty
//   out: grant[NUM_REQ], done[NUM_REQ], err[NUM_REQ], tx_data[8], ld_tx_data, tx_enable
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic                   arb_enable;
  logic [NUM_REQ-1:0]     req;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     done;
  logic [NUM_REQ-1:0]     err;
  logic [7:0]             tx_data;
  logic                   ld_tx_data;
  logic                   tx_enable;
  logic                   tx_empty;

  // Requesters plus the uart, seen from outside the arbiter.
  modport master (
    output arb_enable, req, req_data, tx_empty,
    input  grant, done, err, tx_data, ld_tx_data, tx_enable
  );

  // The arbiter itself.
  modport slave (
    input  arb_enable, req, req_data, tx_empty,
    output grant, done, err, tx_data, ld_tx_data, tx_enable
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin share of one uart transmitter among NUM_REQ byte requesters.
// Latency : grant + tx_data one cycle after a qualifying req in IDLE; done one cycle after synced tx_empty returns.
// Backpressure: one transfer in flight; requesters hold req until done/err; arb_enable=0 blocks new grants only.
// Ports: clk, reset (async, active-high); bus (slave modport): arb_enable, req, req_data,
//        tx_empty in; grant, done, err, tx_data, ld_tx_data, tx_enable out.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY} state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_tx_empty_s;

  logic [NUM_REQ-1:0]   r_grant,   w_grant_nxt;
  logic [NUM_REQ-1:0]   r_done,    w_done_nxt;
  logic [NUM_REQ-1:0]   r_err,     w_err_nxt;
  logic [7:0]           r_tx_data, w_tx_data_nxt;
  logic                 r_ld,      w_ld_nxt;
  logic                 r_tx_enable;
  logic [IW-1:0]        r_ptr,     w_ptr_nxt;
  logic [IW-1:0]        r_owner,   w_owner_nxt;
  logic [CW-1:0]        r_cnt,     w_cnt_nxt;

  logic [IW-1:0]        w_win;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic [IW-1:0]        w_ptr_after;
  logic                 w_start;
  logic                 w_timeout;
  int                   w_idx;

  assign w_tx_empty_s = r_sync2;

  // Walk offsets from the highest down so the lowest offset from r_ptr wins.
  always_comb begin
    w_win = '0;
    w_idx = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (bus.req[IW'(w_idx)]) w_win = IW'(w_idx);
    end
  end

  assign w_win_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_after = (r_owner == IW'(NUM_REQ - 1)) ? '0 : r_owner + IW'(1);
  // tx_empty_s=1 in IDLE keeps us from loading while the uart is still shifting.
  assign w_start     = (r_state == S_IDLE) && bus.arb_enable && (|bus.req) && w_tx_empty_s;
  assign w_timeout   = (r_cnt == CW'(BUSY_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (!w_tx_empty_s)  w_state_nxt = S_BUSY;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_BUSY: if (w_tx_empty_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; r_grant doubles as the owner one-hot for done/err.
  always_comb begin
    w_grant_nxt   = r_grant;
    w_tx_data_nxt = r_tx_data;
    w_ld_nxt      = r_ld;
    w_done_nxt    = '0;
    w_err_nxt     = '0;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_cnt_nxt     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_grant_nxt   = w_win_oh;
          w_tx_data_nxt = bus.req_data[{w_win, 3'b000} +: 8];
          w_ld_nxt      = 1'b1;
          w_owner_nxt   = w_win;
        end
      end
      S_LOAD: begin
        if (!w_tx_empty_s) begin
          w_ld_nxt = 1'b0;
        end else if (w_timeout) begin
          w_err_nxt   = r_grant;
          w_grant_nxt = '0;
          w_ld_nxt    = 1'b0;
          w_ptr_nxt   = w_ptr_after;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_BUSY: begin
        if (w_tx_empty_s) begin
          w_done_nxt  = r_grant;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_after;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_ld_nxt    = 1'b0;
      end
    endcase
  end

  // Synchroniser flops reset to 1 so a freshly reset arbiter sees an idle uart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_grant     <= '0;
      r_done      <= '0;
      r_err       <= '0;
      r_tx_data   <= '0;
      r_ld        <= 1'b0;
      r_tx_enable <= 1'b0;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
    end else begin
      r_sync1     <= bus.tx_empty;
      r_sync2     <= r_sync1;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_ld        <= w_ld_nxt;
      r_tx_enable <= bus.arb_enable;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.tx_data    = r_tx_data;
  assign bus.ld_tx_data = r_ld;
  assign bus.tx_enable  = r_tx_enable;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart transmitter among NUM_REQ byte-producing requesters using round-robin arbitration.
- Sequences the transmitter's load handshake: drives tx_data and ld_tx_data, and tracks tx_empty to know when the byte has gone out.
- Signals completion or timeout error back to the granted requester.
- Sits between on-chip clients (debug console, status reporter, etc.) and the uart tx side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_TIMEOUT, 64, clk cycles allowed after asserting ld_tx_data for tx_empty to go low before the transfer is aborted.

Ports:
- clk  input  1  system clock; all logic rises on posedge.
- reset  input  1  asynchronous, active-high reset.
- arb_enable  input  1  1 = new grants may be issued; 0 = no new grants (an in-flight transfer still completes).
- req  input  NUM_REQ  per-requester request level. Held high with stable data until its done or err pulse.
- req_data  input  8*NUM_REQ  byte for requester k, in bits [8k+7:8k].
- grant  output  NUM_REQ  one-hot; the current owner of the transmitter.
- done  output  NUM_REQ  one-cycle pulse to the owner when its byte has been fully sent.
- err  output  NUM_REQ  one-cycle pulse to the owner on BUSY_TIMEOUT.
- tx_data  output  8  to uart tx_data.
- ld_tx_data  output  1  to uart ld_tx_data. The uart acts on its rising edge.
- tx_enable  output  1  to uart tx_enable.
- tx_empty  input  1  from uart, in the txclk domain; synchronised internally.

Behaviour:
- Reset values: grant=0, done=0, err=0, tx_data=0, ld_tx_data=0, tx_enable=0, state=IDLE, rr pointer=0, timeout counter=0, both synchroniser flops=1.
- tx_empty passes through a 2-flop synchroniser; tx_empty_s is its output, so it lags tx_empty by 2 cycles.
- tx_enable is a registered copy of arb_enable (1 cycle latency).
- State IDLE, entered when: arb_enable=1, req!=0 and tx_empty_s=1.
  - Winner = first set req bit searching from index ptr upward, wrapping modulo NUM_REQ.
  - Registered on the same edge: grant=onehot(winner), tx_data=req_data[winner].
  - Next state is LOAD.
- State LOAD:
  - ld_tx_data=1 and the counter increments each cycle.
  - If tx_empty_s=0: ld_tx_data goes to 0, counter clears, next state is BUSY.
  - Else if counter reaches BUSY_TIMEOUT-1: err[winner] pulses, grant and ld_tx_data go to 0, ptr=winner+1 mod NUM_REQ, next state is IDLE.
- State BUSY:
  - When tx_empty_s=1: done[winner] pulses for 1 cycle, grant goes to 0, ptr=winner+1 mod NUM_REQ, next state is IDLE.
  - There is no timeout in BUSY.
- ld_tx_data is low for at least one cycle between transfers, because IDLE always separates them. Every load therefore presents a fresh rising edge.
- tx_data is stable from the grant until the return to IDLE.
- A requester that drops req mid-transfer does not abort it. done/err still pulse to that index.
- A req raised while another index is granted waits for the next arbitration.
- arb_enable falling in LOAD or BUSY: the transfer completes normally; no new grant is issued.
- A req bit equal to ptr has highest priority.
  - With all requesters continuously requesting, the grant order is 0,1,2,3,0,...
- reset asserted mid-transfer: all outputs return to reset values immediately. No done or err is issued.
- Minimum cost per byte: 1 (IDLE) + LOAD until the synchronised busy is seen + BUSY duration.

Test Plan:
1. Single request: req=4'b0010, req_data[15:8]=8'hA5, uart model drops tx_empty 3 txclk after ld and raises it 10 txclk later -> grant=4'b0010, tx_data=8'hA5, ld_tx_data pulse, done[1] exactly once, ptr=2.
2. All four requesting with data 8'h10..8'h13 -> grant order 0,1,2,3, then 0 again; bytes appear at the uart in the order 10,11,12,13; each done pulses once.
3. Timeout: tx_empty held at 1 after load -> err[owner] pulses on cycle BUSY_TIMEOUT of LOAD; no done; the next requester is then granted.
4. Fairness after idle gap: req0 served, then req0 and req3 assert together -> req3 granted first (ptr=1).
5. arb_enable=0 during BUSY with req2 pending -> current done fires; no grant while disabled; req2 granted within 2 cycles of re-enable.
6. reset asserted in BUSY -> grant, ld_tx_data, done and err are 0 immediately; after release, the pending req is re-arbitrated starting from index 0.
